mips_memory: RTL and testbench
==============================

MIPS_MEMORY -- requirements
Module: mips_memory

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, memory size in bytes; a power of two, at least 16.
REQ-002 SHALL have parameter ADDR_W, default $clog2(MEM_BYTES), the number of internal byte-address bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_addr  input  32  instruction fetch byte address from the core.
REQ-006 SHALL have port inst  output  32  fetched instruction word.
REQ-007 SHALL have port mem_addr  input  32  data byte address from the core.
REQ-008 SHALL have port mem_data_in  input  4x8 (array [0:3])  store data from the core.
REQ-009 SHALL have port mem_data_out  output  4x8 (array [0:3])  load data to the core.
REQ-010 SHALL have port mem_write_en  input  1  core store request.
REQ-011 SHALL have port halted  input  1  core halt indication.
REQ-012 SHALL have port ld_valid  input  1  program-load byte valid.
REQ-013 SHALL have port ld_byte  input  8  program-load byte.
REQ-014 SHALL have port ld_last  input  1  marks the final load byte; qualified by ld_valid.
REQ-015 SHALL have port ld_ready  output  1  load port accepts a byte.
REQ-016 SHALL have port core_rst_b  output  1  active-low reset to the core; registered.
REQ-017 SHALL have port align_err  output  1  sticky misaligned-access flag.
REQ-018 SHALL have port ld_ovf  output  1  sticky flag: the load pointer wrapped.

Function
REQ-019 SHALL store bytes in a MEM_BYTES array; the byte index is address[ADDR_W-1:0], and higher address bits are ignored (wrap).
REQ-020 SHALL use big-endian lanes: lane k (k=0..3) maps to byte {a[ADDR_W-1:2],2'b00}+k, and lane 0 is the most significant byte.
REQ-021 SHALL drive inst = {lane0,lane1,lane2,lane3} of inst_addr combinationally, with zero cycles latency.
REQ-022 SHALL drive mem_data_out[k] = lane k of mem_addr combinationally.
REQ-023 SHALL ignore address bits [1:0] for all accesses; every access is word-aligned down.
REQ-024 SHALL set align_err on the clock edge where state=RUN and either inst_addr[1:0]!=0, or mem_write_en=1 with mem_addr[1:0]!=0; align_err is cleared only by reset.
REQ-025 SHALL implement an FSM with states LOAD, RUN and HALT.
REQ-026 In LOAD: ld_ready=1, core_rst_b=0 and core stores are ignored; each handshake (ld_valid&ld_ready) writes ld_byte at ld_ptr and increments ld_ptr modulo MEM_BYTES.
REQ-027 SHALL set ld_ovf when ld_ptr wraps from MEM_BYTES-1 to 0 on a handshake.
REQ-028 A handshake with ld_last=1 SHALL write its byte and move the FSM to RUN; core_rst_b rises on that same edge, so it is high from the next cycle.
REQ-029 ld_valid=0 SHALL leave ld_ptr and memory unchanged, with no timeout.
REQ-030 In RUN: ld_ready=0 and load inputs are ignored; when mem_write_en=1 and halted=0, all four lanes of mem_data_in are written at the rising edge.
REQ-031 A RUN load and store to the same word in one cycle SHALL return the old data that cycle and the new data from the next cycle.
REQ-032 halted=1 in RUN SHALL move the FSM to HALT at the next edge, and a store in that same cycle SHALL be suppressed.
REQ-033 HALT SHALL keep core_rst_b=1, ld_ready=0 and block all writes while reads continue; HALT exits only via reset.
REQ-034 SHALL make inst and data reads of the same word in one cycle return identical data.

Reset
REQ-035 While rst_b=0: state=LOAD, ld_ptr=0, core_rst_b=0, ld_ready=1, align_err=0, ld_ovf=0.
REQ-036 Reset SHALL NOT clear memory contents; a reset in any state, including mid-load, restarts loading at address 0.
REQ-037 Deassertion of rst_b SHALL be synchronized so that the first handshake is taken on the second rising edge after deassertion.

Verification
REQ-038 Load 8 bytes 01..08 with ld_last on byte 8, then set inst_addr=4 -> inst=0x05060708, core_rst_b=1 one cycle after the last handshake, ld_ovf=0.
REQ-039 In RUN, store mem_addr=0x10 with data {AA,BB,CC,DD} -> same cycle mem_data_out shows the old word; next cycle shows AA,BB,CC,DD, and inst_addr=0x10 gives 0xAABBCCDD.
REQ-040 Store with mem_addr=0x1013 at MEM_BYTES=4096 -> word 0x010 is written and align_err=1 from the next cycle.
REQ-041 Store with halted=1 in the same cycle -> no write occurs, the FSM enters HALT, ld_ready=0, and later stores have no effect.
REQ-042 Load 4097 bytes at MEM_BYTES=4096 -> ld_ovf=1 and byte 0 holds the 4097th value.
REQ-043 Pulse rst_b low mid-load after 3 bytes -> core_rst_b=0, ld_ptr=0, and the next byte is written at address 0.

Source files
------------

// File: rtl/mips_memory.sv
// -----------------------------------------------------------------------------
// mips_memory
// Unified byte-addressed instruction/data memory for a small MIPS core, with a
// byte-serial program-load port and a reset sequencer for the core.
//
// After reset the block is in LOAD. In that state it accepts program bytes
// through the ld_* handshake and holds the core in reset. The byte flagged with
// ld_last releases the core (RUN). In RUN the core fetches and loads
// combinationally and stores whole words on the clock edge. When the core
// signals halted the block freezes memory (HALT) until the next reset.
//
// Ports
//   clk, rst_b        clock, asynchronous active-low reset
//   inst_addr, inst   instruction fetch address / big-endian word (combinational)
//   mem_addr          data address (low two bits ignored)
//   mem_data_in       store lanes, lane 0 = most significant byte
//   mem_data_out      load lanes, lane 0 = most significant byte (combinational)
//   mem_write_en      store request from the core
//   halted            core halt indication
//   ld_valid, ld_byte, ld_last, ld_ready   program-load handshake
//   core_rst_b        registered active-low reset to the core
//   align_err         sticky misaligned-access flag
//   ld_ovf            sticky flag, load pointer wrapped past the top of memory
// -----------------------------------------------------------------------------
module mips_memory #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in  [0:3],
    output logic [7:0]  mem_data_out [0:3],
    input  logic        mem_write_en,
    input  logic        halted,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_rst_b,
    output logic        align_err,
    output logic        ld_ovf
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        mem_r [0:MEM_BYTES-1];
    logic [ADDR_W-1:0] ld_ptr_r;
    logic              rst_sync_r;
    logic              core_rst_b_r;
    logic              align_err_r;
    logic              ld_ovf_r;

    logic [ADDR_W-1:0] inst_base_s;
    logic [ADDR_W-1:0] data_base_s;
    logic [31:0]       inst_s;
    logic              ld_ready_s;
    logic              handshake_s;
    logic              store_s;
    logic              misalign_s;
    logic              ptr_wrap_s;
    logic              unused_addr_bits_s;

    // Upper address bits are deliberately ignored: the memory aliases (wraps).
    assign unused_addr_bits_s = ^{inst_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    // Every access is forced down to its word boundary.
    assign inst_base_s = {inst_addr[ADDR_W-1:2], 2'b00};
    assign data_base_s = {mem_addr[ADDR_W-1:2], 2'b00};

    assign ld_ready_s  = (state_r == ST_LOAD);
    // rst_sync_r is still low on the first edge after reset release, so the
    // first byte is only accepted on the second edge.
    assign handshake_s = ld_valid & ld_ready_s & rst_sync_r;
    assign store_s     = (state_r == ST_RUN) & mem_write_en & ~halted;
    assign ptr_wrap_s  = (ld_ptr_r == ADDR_W'(MEM_BYTES - 1));
    assign misalign_s  = (inst_addr[1:0] != 2'b00) |
                         (mem_write_en & (mem_addr[1:0] != 2'b00));

    // Combinational big-endian read of both ports from the same array, so an
    // instruction fetch and a data load of one word always agree.
    always_comb begin
        inst_s = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            inst_s[31 - 8*k -: 8] = mem_r[inst_base_s | ADDR_W'(k)];
            mem_data_out[k]       = mem_r[data_base_s | ADDR_W'(k)];
        end
    end

    assign inst = inst_s;

    // Next-state logic of the LOAD / RUN / HALT sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (handshake_s && ld_last) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (halted) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_LOAD;
            end
        endcase
    end

    // State, load pointer, core reset and sticky status flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r      <= ST_LOAD;
            ld_ptr_r     <= '0;
            rst_sync_r   <= 1'b0;
            core_rst_b_r <= 1'b0;
            align_err_r  <= 1'b0;
            ld_ovf_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            rst_sync_r   <= 1'b1;
            // Core leaves reset on the same edge the FSM leaves LOAD.
            core_rst_b_r <= (state_nxt_s != ST_LOAD);
            if (handshake_s) begin
                ld_ptr_r <= ld_ptr_r + ADDR_W'(1);
                if (ptr_wrap_s) begin
                    ld_ovf_r <= 1'b1;
                end
            end
            if ((state_r == ST_RUN) && misalign_s) begin
                align_err_r <= 1'b1;
            end
        end
    end

    // Memory array write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (handshake_s) begin
            mem_r[ld_ptr_r] <= ld_byte;
        end else if (store_s) begin
            for (int k = 0; k < 4; k++) begin
                mem_r[data_base_s | ADDR_W'(k)] <= mem_data_in[k];
            end
        end
    end

    assign ld_ready   = ld_ready_s;
    assign core_rst_b = core_rst_b_r;
    assign align_err  = align_err_r;
    assign ld_ovf     = ld_ovf_r;

endmodule

// File: tb/tb_mips_memory.sv
// -----------------------------------------------------------------------------
// tb_mips_memory
// Directed, self-checking bench for mips_memory at MEM_BYTES=4096: program
// load, big-endian reads, store timing, address wrap, alignment flag, halt,
// mid-load reset and load-pointer overflow.
// -----------------------------------------------------------------------------
module tb_mips_memory;

    logic        clk;
    logic        rst_b;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic [31:0] mem_addr;
    logic [7:0]  din  [0:3];
    logic [7:0]  dout [0:3];
    logic        mem_write_en;
    logic        halted;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        core_rst_b;
    logic        align_err;
    logic        ld_ovf;
    logic [31:0] dout_w;

    int total;
    int bad;

    typedef struct packed {
        logic [31:0] ia;
        logic [31:0] ma;
        logic        we;
        logic [31:0] d;
        logic [31:0] e_inst;
        logic [31:0] e_mem;
        logic        chk_m;
        logic        e_al;
    } vec_t;

    vec_t vecs [0:7];

    mips_memory dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .inst_addr    (inst_addr),
        .inst         (inst),
        .mem_addr     (mem_addr),
        .mem_data_in  (din),
        .mem_data_out (dout),
        .mem_write_en (mem_write_en),
        .halted       (halted),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .core_rst_b   (core_rst_b),
        .align_err    (align_err),
        .ld_ovf       (ld_ovf)
    );

    assign dout_w = {dout[0], dout[1], dout[2], dout[3]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_din(input logic [31:0] w);
        din[0] = w[31:24];
        din[1] = w[23:16];
        din[2] = w[15:8];
        din[3] = w[7:0];
    endtask

    // One cycle of load-port stimulus, ending on the rising edge.
    task automatic send(input logic v, input logic [7:0] b, input logic last);
        @(negedge clk);
        ld_valid = v;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
    endtask

    // Release reset with the first byte already offered; the edge right after
    // release must not take it, so the caller offers it once more.
    task automatic release_and_first(input logic [7:0] b);
        @(negedge clk);
        rst_b    = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = 1'b0;
        @(posedge clk);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_b        = 1'b0;
        ld_valid     = 1'b0;
        mem_write_en = 1'b0;
        halted       = 1'b0;
        #1;
        chk("rst_core_rst_b", {31'd0, core_rst_b}, 32'd0);
        chk("rst_ld_ready",   {31'd0, ld_ready},   32'd1);
        chk("rst_align_err",  {31'd0, align_err},  32'd0);
        chk("rst_ld_ovf",     {31'd0, ld_ovf},     32'd0);
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [31:0] t;
        t = i;
        return t[7:0] ^ 8'h5A;
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        //           ia            ma            we    d             e_inst        e_mem         chk   al
        vecs[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0,        32'h0102_0304, 32'h0506_0708, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0000_0010, 1'b1, 32'h1122_3344, 32'h0506_0708, 32'h0,        1'b0, 1'b0};
        vecs[2] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0,        32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_1010, 32'h0000_2004, 1'b0, 32'h0,        32'hAABB_CCDD, 32'h0506_0708, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_1013, 1'b1, 32'hCAFE_F00D, 32'h0102_0304, 32'hAABB_CCDD, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_0013, 32'h0000_0012, 1'b0, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b1};

        rst_b        = 1'b0;
        inst_addr    = 32'h0;
        mem_addr     = 32'h0;
        mem_write_en = 1'b0;
        halted       = 1'b0;
        ld_valid     = 1'b0;
        ld_byte      = 8'h00;
        ld_last      = 1'b0;
        set_din(32'h0);
        repeat (2) @(posedge clk);
        enter_reset();

        // Program load 01..08 with an idle cycle in the middle.
        release_and_first(8'h01);
        send(1'b1, 8'h01, 1'b0);
        send(1'b1, 8'h02, 1'b0);
        send(1'b1, 8'h03, 1'b0);
        send(1'b0, 8'hEE, 1'b0);
        send(1'b1, 8'h04, 1'b0);
        send(1'b1, 8'h05, 1'b0);
        send(1'b1, 8'h06, 1'b0);
        send(1'b1, 8'h07, 1'b0);
        #1;
        chk("load_core_rst_low", {31'd0, core_rst_b}, 32'd0);
        send(1'b1, 8'h08, 1'b1);
        #1;
        chk("load_core_rst_high", {31'd0, core_rst_b}, 32'd1);
        chk("run_ld_ready",       {31'd0, ld_ready},   32'd0);
        chk("load_ld_ovf",        {31'd0, ld_ovf},     32'd0);

        // RUN-state vector table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ld_valid     = 1'b0;
            inst_addr    = vecs[i].ia;
            mem_addr     = vecs[i].ma;
            mem_write_en = vecs[i].we;
            set_din(vecs[i].d);
            #1;
            chk($sformatf("vec%0d_inst", i), inst, vecs[i].e_inst);
            if (vecs[i].chk_m) begin
                chk($sformatf("vec%0d_mem", i), dout_w, vecs[i].e_mem);
            end
            chk($sformatf("vec%0d_align", i), {31'd0, align_err}, {31'd0, vecs[i].e_al});
        end

        // Store together with halt: suppressed, then HALT blocks later stores.
        @(negedge clk);
        inst_addr    = 32'h10;
        mem_addr     = 32'h10;
        mem_write_en = 1'b1;
        halted       = 1'b1;
        set_din(32'h5555_5555);
        @(negedge clk);
        halted = 1'b0;
        set_din(32'h6666_6666);
        #1;
        chk("halt_no_write",   dout_w, 32'hCAFE_F00D);
        chk("halt_ld_ready",   {31'd0, ld_ready},   32'd0);
        chk("halt_core_rst_b", {31'd0, core_rst_b}, 32'd1);
        @(negedge clk);
        mem_write_en = 1'b0;
        #1;
        chk("halt_later_store", inst, 32'hCAFE_F00D);

        // Reset in HALT, then again mid-load after three bytes.
        enter_reset();
        inst_addr = 32'h3;
        release_and_first(8'h21);
        send(1'b1, 8'h21, 1'b0);
        send(1'b1, 8'h22, 1'b0);
        send(1'b1, 8'h23, 1'b0);
        enter_reset();
        release_and_first(8'h31);
        send(1'b1, 8'h31, 1'b0);
        send(1'b1, 8'h32, 1'b0);
        send(1'b1, 8'h33, 1'b0);
        send(1'b1, 8'h34, 1'b1);
        #1;
        chk("reload_core_rst_b", {31'd0, core_rst_b}, 32'd1);
        chk("load_no_align",     {31'd0, align_err},  32'd0);
        @(negedge clk);
        ld_valid  = 1'b0;
        inst_addr = 32'h0;
        #1;
        chk("reload_word0", inst, 32'h3132_3334);
        @(negedge clk);
        inst_addr = 32'h4;
        #1;
        chk("mem_kept_word1", inst, 32'h0506_0708);
        @(negedge clk);
        inst_addr = 32'h1;
        @(negedge clk);
        #1;
        chk("inst_misalign", {31'd0, align_err}, 32'd1);
        chk("inst_low_bits", inst, 32'h3132_3334);

        // Overflow: 4097 handshakes, the last one lands at byte 0.
        enter_reset();
        inst_addr = 32'h0;
        release_and_first(pat(0));
        send(1'b1, pat(0), 1'b0);
        for (int i = 1; i < 4095; i++) begin
            send(1'b1, pat(i), 1'b0);
        end
        #1;
        chk("ovf_before_wrap", {31'd0, ld_ovf}, 32'd0);
        send(1'b1, pat(4095), 1'b0);
        #1;
        chk("ovf_after_wrap", {31'd0, ld_ovf}, 32'd1);
        send(1'b1, 8'hE7, 1'b1);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("ovf_word0",      inst, 32'hE75B_5859);
        chk("ovf_sticky",     {31'd0, ld_ovf},     32'd1);
        chk("ovf_core_rst_b", {31'd0, core_rst_b}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
